sc_io_port_bank: RTL

//  Parametrised memory-mapped I/O port bank for sc_computer, generalising the fixed
//  in_port0/1 / out_port0/1 pair to NUM_IN inputs and NUM_OUT outputs.

---
 rtl/sc_io_port_bank.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sc_io_port_bank.sv
// sc_io_port_bank
//   Memory-mapped I/O port bank for sc_computer. It provides NUM_IN input ports and
//   NUM_OUT output ports. Each input passes through a 2-flop synchroniser and then a
//   debouncer. A sticky change flag is set whenever the debounced value updates.
//   Output ports are plain CPU-writable registers.
//
// Ports
//   clock      : rising-edge clock
//   resetn     : synchronous active-low reset
//   addr       : word address of the bus access (ADDR_W)
//   wdata      : write data (DATA_W)
//   we / re    : write / read strobes, sampled on the rising edge
//   rdata      : registered read data (DATA_W)
//   in_port    : asynchronous inputs, port k at [k*DATA_W +: DATA_W]
//   out_port   : output registers, same packing as in_port
//   in_changed : sticky per-port change flags, write-1-to-clear at IN_BASE+NUM_IN
//   irq        : high while any in_changed bit is set
module sc_io_port_bank #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_IN   = 2,
  parameter int                NUM_OUT  = 2,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] IN_BASE  = 'h80,
  parameter logic [ADDR_W-1:0] OUT_BASE = 'hC0,
  parameter int                DEB_CYC  = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      we,
  input  logic                      re,
  output logic [DATA_W-1:0]         rdata,
  input  logic [NUM_IN*DATA_W-1:0]  in_port,
  output logic [NUM_OUT*DATA_W-1:0] out_port,
  output logic [NUM_IN-1:0]         in_changed,
  output logic                      irq
);

  localparam int                CNT_W     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEB_CYC - 1);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(IN_BASE + NUM_IN);

  logic [DATA_W-1:0] sync_p0   [NUM_IN];
  logic [DATA_W-1:0] sync_p1   [NUM_IN];
  logic [DATA_W-1:0] last_p2   [NUM_IN];
  logic [CNT_W-1:0]  cnt_p2    [NUM_IN];
  logic [DATA_W-1:0] stable_p3 [NUM_IN];
  logic [DATA_W-1:0] out_reg   [NUM_OUT];

  logic [NUM_IN-1:0] chg_set;
  logic [NUM_IN-1:0] chg_clr;
  logic [DATA_W-1:0] rd_mux;

  // Stage p0/p1: two-flop synchroniser; stage p2: debounce tracking; stage p3: accepted value
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_IN; k++) begin
        sync_p0[k]   <= '0;
        sync_p1[k]   <= '0;
        last_p2[k]   <= '0;
        cnt_p2[k]    <= '0;
        stable_p3[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        sync_p0[k] <= in_port[k*DATA_W +: DATA_W];
        sync_p1[k] <= sync_p0[k];
        if (sync_p1[k] != last_p2[k]) begin
          last_p2[k] <= sync_p1[k];
          cnt_p2[k]  <= '0;
        end else if (cnt_p2[k] != CNT_MAX) begin
          cnt_p2[k] <= cnt_p2[k] + CNT_W'(1);
        end else if (last_p2[k] != stable_p3[k]) begin
          stable_p3[k] <= last_p2[k];
        end
      end
    end
  end

  // Set and clear masks for the sticky flags; the counter never exceeds CNT_MAX,
  // so equality stands in for "counted long enough".
  always_comb begin
    chg_set = '0;
    chg_clr = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      chg_set[k] = (sync_p1[k] == last_p2[k]) && (cnt_p2[k] == CNT_MAX) &&
                   (last_p2[k] != stable_p3[k]);
    end
    if (we && (addr == STAT_ADDR)) begin
      chg_clr = wdata[NUM_IN-1:0];
    end
  end

  // A fresh change wins over a simultaneous write-1-to-clear of the same bit
  always_ff @(posedge clock) begin
    if (!resetn) begin
      in_changed <= '0;
    end else begin
      in_changed <= (in_changed & ~chg_clr) | chg_set;
    end
  end

  assign irq = |in_changed;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        out_reg[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (we && (addr == ADDR_W'(OUT_BASE + j))) begin
          out_reg[j] <= wdata;
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out_pack
    assign out_port[j*DATA_W +: DATA_W] = out_reg[j];
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (addr == ADDR_W'(IN_BASE + k)) begin
        rd_mux = stable_p3[k];
      end
    end
    if (addr == STAT_ADDR) begin
      rd_mux = DATA_W'(in_changed);
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (addr == ADDR_W'(OUT_BASE + j)) begin
        rd_mux = out_reg[j];
      end
    end
  end

  // Read data samples pre-write register contents, so a same-cycle write returns the old value
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_mux;
    end
  end

endmodule
